// File: rtl/register_file_mp.sv
// register_file_mp: multi-ported register file with a per-register scoreboard
// busy bit. Two combinational read ports, two write ports (B wins on an
// address collision), and one reservation port that sets a busy bit.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data onto the read ports (port B over port A). The default build has no
// bypass, so reads show stored state only.

// One storage entry: data word plus its scoreboard busy bit.
module register_file_mp_entry #(
  parameter int DATA_W = 32
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic              wea_i,
  input  logic              web_i,
  input  logic [DATA_W-1:0] dina_i,
  input  logic [DATA_W-1:0] dinb_i,
  input  logic              rsv_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;

  // Next state: B write overrides A; a reservation overrides the write's busy clear.
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    if (web_i)       data_d = dinb_i;
    else if (wea_i)  data_d = dina_i;
    if (wea_i || web_i) busy_d = 1'b0;
    if (rsv_i)          busy_d = 1'b1;
  end

  // State registers; reset clears data and busy at once, without waiting for a clock.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;
endmodule

module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic [ADDR_W-1:0] Adr1_i,
  input  logic [ADDR_W-1:0] Adr2_i,
  output logic [DATA_W-1:0] Dout1_o,
  output logic [DATA_W-1:0] Dout2_o,
  output logic              Busy1_o,
  output logic              Busy2_o,
  input  logic [ADDR_W-1:0] AwrA_i,
  input  logic [ADDR_W-1:0] AwrB_i,
  input  logic [DATA_W-1:0] DinA_i,
  input  logic [DATA_W-1:0] DinB_i,
  input  logic              WrEnA_i,
  input  logic              WrEnB_i,
  input  logic              Rsv_i,
  input  logic [ADDR_W-1:0] RsvAdr_i
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] rd_data;
  logic [DEPTH-1:0]             rd_busy;

  // One entry per address; entry 0 is a constant zero when ZERO_REG is set,
  // so writes and reservations aimed at it simply have nowhere to land.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    if (ZERO_REG && i == 0) begin : g_zero
      assign rd_data[i] = '0;
      assign rd_busy[i] = 1'b0;
    end else begin : g_reg
      logic wea, web, rsv;
      assign wea = WrEnA_i && (AwrA_i   == ADDR_W'(i));
      assign web = WrEnB_i && (AwrB_i   == ADDR_W'(i));
      assign rsv = Rsv_i   && (RsvAdr_i == ADDR_W'(i));
      register_file_mp_entry #(.DATA_W(DATA_W)) u_entry (
        .Clk_i  (Clk_i),
        .Rst_i  (Rst_i),
        .wea_i  (wea),
        .web_i  (web),
        .dina_i (DinA_i),
        .dinb_i (DinB_i),
        .rsv_i  (rsv),
        .data_o (rd_data[i]),
        .busy_o (rd_busy[i])
      );
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding mux: same-cycle write data beats stored data, B beats A.
  // Suppressed during reset and for the hardwired zero register.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [ADDR_W-1:0] adr,
    input logic [DATA_W-1:0] stored,
    input logic              rst,
    input logic              wea,
    input logic [ADDR_W-1:0] awra,
    input logic [DATA_W-1:0] dina,
    input logic              web,
    input logic [ADDR_W-1:0] awrb,
    input logic [DATA_W-1:0] dinb
  );
    logic [DATA_W-1:0] r;
    r = stored;
    if (!rst && !(ZERO_REG && adr == '0)) begin
      if (web && awrb == adr)      r = dinb;
      else if (wea && awra == adr) r = dina;
    end
    return r;
  endfunction

  // Read ports with write-data forwarding.
  always_comb begin
    Dout1_o = fwd(Adr1_i, rd_data[Adr1_i], Rst_i, WrEnA_i, AwrA_i, DinA_i,
                  WrEnB_i, AwrB_i, DinB_i);
    Dout2_o = fwd(Adr2_i, rd_data[Adr2_i], Rst_i, WrEnA_i, AwrA_i, DinA_i,
                  WrEnB_i, AwrB_i, DinB_i);
  end
`else
  // Read ports show stored state only; a write appears after its clock edge.
  always_comb begin
    Dout1_o = rd_data[Adr1_i];
    Dout2_o = rd_data[Adr2_i];
  end
`endif

  // Busy bits are never forwarded: they always reflect stored scoreboard state.
  always_comb begin
    Busy1_o = rd_busy[Adr1_i];
    Busy2_o = rd_busy[Adr2_i];
  end
endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: stimulus pushes expected read
// results into a queue, and a monitor pops and compares each one against the
// read ports.
module tb_register_file_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              Clk, Rst;
  logic [ADDR_W-1:0] Adr1, Adr2, AwrA, AwrB, RsvAdr;
  logic [DATA_W-1:0] Dout1, Dout2, DinA, DinB;
  logic              Busy1, Busy2, WrEnA, WrEnB, Rsv;

  register_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) dut (
    .Clk_i(Clk), .Rst_i(Rst),
    .Adr1_i(Adr1), .Adr2_i(Adr2),
    .Dout1_o(Dout1), .Dout2_o(Dout2),
    .Busy1_o(Busy1), .Busy2_o(Busy2),
    .AwrA_i(AwrA), .AwrB_i(AwrB),
    .DinA_i(DinA), .DinB_i(DinB),
    .WrEnA_i(WrEnA), .WrEnB_i(WrEnB),
    .Rsv_i(Rsv), .RsvAdr_i(RsvAdr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    string             nm;
    int                port;
    logic [DATA_W-1:0] d;
    logic              b;
  } exp_t;

  exp_t sb[$];
  int   pushed = 0, popped = 0;
  int   checks = 0, fails = 0;

  // Monitor: compare each queued expectation against the addressed read port.
  initial begin
    exp_t              e;
    logic [DATA_W-1:0] ad;
    logic              ab;
    forever begin
      wait (popped < pushed);
      e = sb.pop_front();
      popped++;
      ad = (e.port == 1) ? Dout1 : Dout2;
      ab = (e.port == 1) ? Busy1 : Busy2;
      checks++;
      if (ad !== e.d) begin
        fails++;
        $display("FAIL %s: Dout%0d got %h want %h", e.nm, e.port, ad, e.d);
      end
      checks++;
      if (ab !== e.b) begin
        fails++;
        $display("FAIL %s: Busy%0d got %b want %b", e.nm, e.port, ab, e.b);
      end
    end
  end

  // Point a read port at adr, let it settle, then queue the expected result.
  task automatic expect_rd(input string nm, input int port, input logic [ADDR_W-1:0] adr,
                           input logic [DATA_W-1:0] d, input logic b);
    if (port == 1) Adr1 = adr; else Adr2 = adr;
    #1;
    sb.push_back('{nm, port, d, b});
    pushed++;
    #1;
  endtask

  // Advance past the next rising edge, then drop all enables.
  task automatic step();
    @(posedge Clk);
    #1;
    WrEnA = 1'b0; WrEnB = 1'b0; Rsv = 1'b0;
  endtask

  task automatic wr_a(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    WrEnA = 1'b1; AwrA = a; DinA = d;
  endtask

  task automatic wr_b(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    WrEnB = 1'b1; AwrB = a; DinB = d;
  endtask

  task automatic rsv(input logic [ADDR_W-1:0] a);
    Rsv = 1'b1; RsvAdr = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1;
    Adr1 = '0; Adr2 = '0; AwrA = '0; AwrB = '0; RsvAdr = '0;
    DinA = '0; DinB = '0; WrEnA = 1'b0; WrEnB = 1'b0; Rsv = 1'b0;
    #1;
    expect_rd("reset_r1", 1, 5'd1, 32'h0, 1'b0);
    expect_rd("reset_r5", 2, 5'd5, 32'h0, 1'b0);
    @(negedge Clk);
    Rst = 1'b0;
    step();

    // Basic write, one-cycle latency
    wr_a(5'd1, 32'hF0F0_F0F0);
    expect_rd("r1_pre_edge", 1, 5'd1, BYP ? 32'hF0F0_F0F0 : 32'h0, 1'b0);
    step();
    expect_rd("r1_write", 1, 5'd1, 32'hF0F0_F0F0, 1'b0);

    // Zero register ignores writes, reservations and bypass
    wr_a(5'd0, 32'hFFFF_FFFF);
    rsv(5'd0);
    expect_rd("r0_pre_edge", 1, 5'd0, 32'h0, 1'b0);
    step();
    expect_rd("r0_zero", 1, 5'd0, 32'h0, 1'b0);

    // Same-address collision: B wins
    wr_a(5'd3, 32'h1111_1111);
    wr_b(5'd3, 32'h2222_2222);
    step();
    expect_rd("r3_b_wins", 1, 5'd3, 32'h2222_2222, 1'b0);

    // Distinct addresses both land
    wr_a(5'd4, 32'h4444_4444);
    wr_b(5'd5, 32'h5555_5555);
    step();
    expect_rd("r4_dual", 1, 5'd4, 32'h4444_4444, 1'b0);
    expect_rd("r5_dual", 2, 5'd5, 32'h5555_5555, 1'b0);

    // Scoreboard set / clear / reservation-wins
    rsv(5'd7);
    step();
    expect_rd("r7_rsv", 1, 5'd7, 32'h0, 1'b1);
    wr_a(5'd7, 32'h0F0F_0F0F);
    step();
    expect_rd("r7_wr_clr", 1, 5'd7, 32'h0F0F_0F0F, 1'b0);
    rsv(5'd7);
    wr_b(5'd7, 32'h7777_7777);
    step();
    expect_rd("r7_rsv_wins", 1, 5'd7, 32'h7777_7777, 1'b1);

    // Bypass visibility before the edge, and B-over-A forwarding
    wr_a(5'd2, 32'hA5A5_A5A5);
    expect_rd("r2_pre_edge", 2, 5'd2, BYP ? 32'hA5A5_A5A5 : 32'h0, 1'b0);
    step();
    expect_rd("r2_write", 2, 5'd2, 32'hA5A5_A5A5, 1'b0);
    wr_a(5'd2, 32'h1234_5678);
    wr_b(5'd2, 32'h5A5A_5A5A);
    expect_rd("r2_fwd_b", 1, 5'd2, BYP ? 32'h5A5A_5A5A : 32'hA5A5_A5A5, 1'b0);
    step();
    expect_rd("r2_b_wins", 1, 5'd2, 32'h5A5A_5A5A, 1'b0);

    // Top address and hold of untouched registers
    wr_b(5'd31, 32'hDEAD_BEEF);
    step();
    expect_rd("r31_write", 2, 5'd31, 32'hDEAD_BEEF, 1'b0);
    expect_rd("r1_hold", 1, 5'd1, 32'hF0F0_F0F0, 1'b0);
    expect_rd("r7_busy_hold", 2, 5'd7, 32'h7777_7777, 1'b1);

    // Reset between edges with a write pending
    wr_a(5'd1, 32'h0F0F_0F0F);
    rsv(5'd6);
    step();
    expect_rd("r1_load", 1, 5'd1, 32'h0F0F_0F0F, 1'b0);
    expect_rd("r6_rsv", 2, 5'd6, 32'h0, 1'b1);
    wr_a(5'd1, 32'h1234_5678);
    Rst = 1'b1;
    expect_rd("rst_async_r1", 1, 5'd1, 32'h0, 1'b0);
    expect_rd("rst_async_r6", 2, 5'd6, 32'h0, 1'b0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    WrEnA = 1'b0;
    step();
    expect_rd("rst_discard_r1", 1, 5'd1, 32'h0, 1'b0);
    expect_rd("rst_r7_cleared", 2, 5'd7, 32'h0, 1'b0);
    wr_a(5'd1, 32'hCAFE_F00D);
    step();
    expect_rd("resume_r1", 1, 5'd1, 32'hCAFE_F00D, 1'b0);

    #20;
    checks++;
    if (popped != pushed) begin
      fails++;
      $display("FAIL scoreboard_drain: popped %0d pushed %0d", popped, pushed);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set address width; depth SHALL be 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1, SHALL make register 0 read as zero and ignore writes when 1.
REQ-004 Clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 Adr1, Adr2  input  ADDR_W  SHALL be the read addresses for ports 1 and 2.
REQ-007 Dout1, Dout2  output  DATA_W  SHALL be the read data for ports 1 and 2.
REQ-008 Busy1, Busy2  output  1  SHALL be the scoreboard busy bits of Adr1 and Adr2.
REQ-009 AwrA, AwrB  input  ADDR_W  SHALL be the write addresses for write ports A and B.
REQ-010 DinA, DinB  input  DATA_W  SHALL be the write data for ports A and B.
REQ-011 WrEnA, WrEnB  input  1  SHALL be the write enables for ports A and B.
REQ-012 Rsv  input  1, RsvAdr  input  ADDR_W  SHALL reserve a register by setting its busy bit.

Function
REQ-013 Reads SHALL be combinational: Doutn = reg[Adrn], Busyn = busy[Adrn], with no clock latency.
REQ-014 A write with WrEnX=1 SHALL update reg[AwrX] on the rising edge of Clk; the value is readable from the following cycle (one-cycle write latency, without bypass).
REQ-015 WrEnA and WrEnB both 1 with AwrA==AwrB: port B SHALL win; the register takes DinB.
REQ-016 Writes to distinct addresses in the same cycle SHALL both take effect.
REQ-017 A write to address X SHALL clear busy[X] on the same edge.
REQ-018 Rsv=1 SHALL set busy[RsvAdr] on the rising edge.
REQ-019 Rsv and a write to the same address in the same cycle: busy SHALL end set (the reservation wins).
REQ-020 ZERO_REG=1: Dout and Busy for address 0 SHALL read 0; writes to and reservations of address 0 SHALL be ignored.
REQ-021 ZERO_REG=0: register 0 SHALL behave like every other register.
REQ-022 Registers not addressed by an enabled write SHALL hold their value.
REQ-023 Addresses SHALL be unsigned; all 2**ADDR_W entries SHALL be valid, with no out-of-range case.

Reset
REQ-024 Rst=1 SHALL clear all registers to 0 and all busy bits to 0 immediately, independent of Clk.
REQ-025 While Rst=1, writes and reservations SHALL be ignored; Dout1/Dout2 SHALL read 0 and Busy1/Busy2 SHALL read 0.
REQ-026 Rst asserted mid-operation SHALL discard the pending write in that cycle; normal operation SHALL resume on the first rising edge after deassertion.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN, when defined, SHALL forward write data combinationally: if WrEnX=1 and AwrX==Adrn (excluding address 0 when ZERO_REG=1), Doutn SHALL show DinX in the same cycle, with port B taking precedence over port A.
REQ-028 Without REGFILE_BYPASS_EN, Doutn SHALL show the pre-write value until after the clock edge.
REQ-029 Bypass SHALL NOT affect Busy outputs or stored state.

Verification
REQ-030 Reset, then write 0xF0F0F0F0 to r1 via port A, read Adr1=1 next cycle -> Dout1=0xF0F0F0F0, Busy1=0.
REQ-031 ZERO_REG=1: write 0xFFFFFFFF to r0, Rsv r0 -> Dout1(Adr1=0)=0, Busy1=0.
REQ-032 Same-cycle writes: AwrA=AwrB=3, DinA=0x11111111, DinB=0x22222222 -> r3=0x22222222; in the same cycle, AwrA=4 and AwrB=5 -> both r4 and r5 are written.
REQ-033 Scoreboard: Rsv r7 -> Busy1(Adr1=7)=1; write r7=0x0F0F0F0F -> Busy1=0; Rsv r7 and write r7 in the same cycle -> Busy1=1.
REQ-034 Bypass: with the macro defined, WrEnA=1, AwrA=2, DinA=0xA5A5A5A5, Adr2=2 -> Dout2=0xA5A5A5A5 before the edge; without the macro -> Dout2 holds the old value until after the edge.
REQ-035 Rst pulsed between clock edges after loading r1=0x0F0F0F0F and Rsv r6 -> Dout1(Adr1=1)=0 and Busy for r6 =0 immediately, before the next edge.
